// File: rtl/mem_responder_if.sv
// mem_responder_if: bundles the loader request channel and the Avalon-MM
// master channel that mem_responder bridges between.
//
// Loader channel: rvalid/raddr -> rready/rdata (read),
//                 wvalid/waddr/wdata -> wready (write).
// Avalon channel: avm_address/avm_read/avm_write/avm_writedata/avm_byteenable
//                 out of the responder; avm_waitrequest/avm_readdata/
//                 avm_readdatavalid back from the fabric.
//
// Modports:
//   slave  - the responder itself (receives loader requests, drives Avalon).
//   master - the environment (loader plus memory fabric) around it.
interface mem_responder_if;
    logic        rvalid;
    logic [25:0] raddr;
    logic        rready;
    logic [31:0] rdata;

    logic        wvalid;
    logic [25:0] waddr;
    logic [31:0] wdata;
    logic        wready;

    logic [27:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport slave (
        input  rvalid, raddr, wvalid, waddr, wdata,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output rready, rdata, wready,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );

    modport master (
        output rvalid, raddr, wvalid, waddr, wdata,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  rready, rdata, wready,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: serves one word-addressed loader read or write at a time by
// issuing a single Avalon-MM transaction, then returns a one-cycle ready pulse.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   bus          mem_responder_if.slave (loader request + Avalon master signals)
//   rd_count     completed reads including timeouts, wraps
//   wr_count     completed writes, wraps
//   timeout_err  sticky, set on any read timeout, cleared only by rst
//
// Parameters:
//   TIMEOUT   cycles to wait for avm_readdatavalid after read acceptance (>= 1)
//   ERR_DATA  rdata returned on read timeout
//
// All outputs are registered. Writes win over reads when both are pending,
// and loader inputs are only sampled in S_IDLE.
module mem_responder #(
    parameter int unsigned TIMEOUT  = 1023,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output logic [31:0]     rd_count,
    output logic [31:0]     wr_count,
    output logic            timeout_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_RESP,
        S_WR_REQ,
        S_WR_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        rready_q, rready_d;
    logic        wready_q, wready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [27:0] avm_address_q, avm_address_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_write_q, avm_write_d;
    logic [31:0] avm_writedata_q, avm_writedata_d;
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic        timeout_err_q, timeout_err_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d         = state_q;
        rready_d        = 1'b0;
        wready_d        = 1'b0;
        rdata_d         = rdata_q;
        avm_address_d   = avm_address_q;
        avm_read_d      = avm_read_q;
        avm_write_d     = avm_write_q;
        avm_writedata_d = avm_writedata_q;
        rd_count_d      = rd_count_q;
        wr_count_d      = wr_count_q;
        timeout_err_d   = timeout_err_q;
        wait_cnt_d      = wait_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // The address/data registers double as the request latches.
                if (bus.wvalid) begin
                    avm_address_d   = {bus.waddr, 2'b00};
                    avm_writedata_d = bus.wdata;
                    avm_write_d     = 1'b1;
                    state_d         = S_WR_REQ;
                end else if (bus.rvalid) begin
                    avm_address_d = {bus.raddr, 2'b00};
                    avm_read_d    = 1'b1;
                    state_d       = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (!bus.avm_waitrequest) begin
                    avm_read_d = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (bus.avm_readdatavalid) begin
                    rdata_d    = bus.avm_readdata;
                    rready_d   = 1'b1;
                    rd_count_d = rd_count_q + 32'd1;
                    state_d    = S_RD_RESP;
                end else if (wait_cnt_q == CntW'(TIMEOUT)) begin
                    rdata_d       = ERR_DATA;
                    timeout_err_d = 1'b1;
                    rready_d      = 1'b1;
                    rd_count_d    = rd_count_q + 32'd1;
                    state_d       = S_RD_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RD_RESP: begin
                state_d = S_IDLE;
            end
            S_WR_REQ: begin
                if (!bus.avm_waitrequest) begin
                    avm_write_d = 1'b0;
                    wready_d    = 1'b1;
                    wr_count_d  = wr_count_q + 32'd1;
                    state_d     = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rready_q        <= 1'b0;
            wready_q        <= 1'b0;
            rdata_q         <= '0;
            avm_address_q   <= '0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            avm_writedata_q <= '0;
            rd_count_q      <= '0;
            wr_count_q      <= '0;
            timeout_err_q   <= 1'b0;
            wait_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            rready_q        <= rready_d;
            wready_q        <= wready_d;
            rdata_q         <= rdata_d;
            avm_address_q   <= avm_address_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            avm_writedata_q <= avm_writedata_d;
            rd_count_q      <= rd_count_d;
            wr_count_q      <= wr_count_d;
            timeout_err_q   <= timeout_err_d;
            wait_cnt_q      <= wait_cnt_d;
        end
    end

    assign bus.rready         = rready_q;
    assign bus.wready         = wready_q;
    assign bus.rdata          = rdata_q;
    assign bus.avm_address    = avm_address_q;
    assign bus.avm_read       = avm_read_q;
    assign bus.avm_write      = avm_write_q;
    assign bus.avm_writedata  = avm_writedata_q;
    assign bus.avm_byteenable = 4'b1111;
    assign rd_count           = rd_count_q;
    assign wr_count           = wr_count_q;
    assign timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with an Avalon slave
// driven from the stimulus tasks and scoreboards of expected Avalon addresses,
// write data and read data checked as the DUT produces them.
module tb_mem_responder;

    localparam int unsigned TB_TIMEOUT = 8;
    localparam logic [31:0] TB_ERR     = 32'hDEADBEEF;

    localparam int SigRd  = 0;
    localparam int SigWr  = 1;
    localparam int SigRrd = 2;
    localparam int SigWrd = 3;

    logic        clk;
    logic        rst;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic        timeout_err;

    mem_responder_if bus ();

    mem_responder #(
        .TIMEOUT  (TB_TIMEOUT),
        .ERR_DATA (TB_ERR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor statistics, written only by the monitor process.
    int both_high   = 0;
    int acc_rd      = 0;
    int rd_pulses   = 0;
    int wr_pulses   = 0;
    int wr_strobe_c = 0;

    logic [27:0] exp_raddr_q[$];
    logic [59:0] exp_wr_q[$];
    logic [31:0] exp_rdata_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            SigRd:   return bus.avm_read;
            SigWr:   return bus.avm_write;
            SigRrd:  return bus.rready;
            SigWrd:  return bus.wready;
            default: return 1'b0;
        endcase
    endfunction

    // Step until the selected signal is high or the budget runs out.
    task automatic wait_for(input int which, input int budget, input string tag, output int n);
        n = 0;
        while (sel(which) !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(sel(which)), 64'd1);
    endtask

    // Scoreboard side: compare DUT activity against expectations at negedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.avm_read && bus.avm_write) both_high++;
            if (bus.avm_write) wr_strobe_c++;
            if (bus.avm_read && !bus.avm_waitrequest) begin
                acc_rd++;
                check("rd_addr_pending", 64'(exp_raddr_q.size() != 0), 64'd1);
                if (exp_raddr_q.size() != 0)
                    check("rd_addr", 64'(bus.avm_address), 64'(exp_raddr_q.pop_front()));
            end
            if (bus.avm_write && !bus.avm_waitrequest) begin
                check("wr_pending", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0)
                    check("wr_addr_data", 64'({bus.avm_address, bus.avm_writedata}),
                          64'(exp_wr_q.pop_front()));
            end
            if (bus.rready) begin
                rd_pulses++;
                check("rdata_pending", 64'(exp_rdata_q.size() != 0), 64'd1);
                if (exp_rdata_q.size() != 0)
                    check("rdata", 64'(bus.rdata), 64'(exp_rdata_q.pop_front()));
            end
            if (bus.wready) wr_pulses++;
        end
    end

    // One loader read; give_data=0 lets the request time out.
    task automatic run_read(input logic [25:0] a, input int ws, input int lat,
                            input logic [31:0] d, input bit give_data);
        int n;
        exp_raddr_q.push_back({a, 2'b00});
        exp_rdata_q.push_back(give_data ? d : TB_ERR);
        bus.rvalid = 1'b1;
        bus.raddr  = a;
        wait_for(SigRd, 10, "rd_strobe_start", n);
        check("rd_avm_address", 64'(bus.avm_address), 64'({a, 2'b00}));
        for (int i = 0; i < ws; i++) begin
            bus.avm_waitrequest = 1'b1;
            step();
            check("rd_strobe_held", 64'(bus.avm_read), 64'd1);
        end
        bus.avm_waitrequest = 1'b0;
        step();
        check("rd_strobe_drop", 64'(bus.avm_read), 64'd0);
        if (give_data) begin
            for (int i = 1; i < lat; i++) step();
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = d;
            step();
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = 32'h0;
            wait_for(SigRrd, 5, "rready_seen", n);
            check("rready_latency", 64'(n), 64'd0);
        end else begin
            wait_for(SigRrd, int'(TB_TIMEOUT) + 20, "rready_timeout_seen", n);
            check("timeout_latency", 64'(n), 64'(TB_TIMEOUT + 1));
        end
        bus.rvalid = 1'b0;
    endtask

    task automatic run_write(input logic [25:0] a, input logic [31:0] d, input int ws);
        int n;
        exp_wr_q.push_back({a, 2'b00, d});
        bus.wvalid = 1'b1;
        bus.waddr  = a;
        bus.wdata  = d;
        wait_for(SigWr, 10, "wr_strobe_start", n);
        check("wr_avm_address", 64'(bus.avm_address), 64'({a, 2'b00}));
        for (int i = 0; i < ws; i++) begin
            bus.avm_waitrequest = 1'b1;
            step();
            check("wr_strobe_held", 64'(bus.avm_write), 64'd1);
            check("wr_addr_stable", 64'(bus.avm_address), 64'({a, 2'b00}));
        end
        bus.avm_waitrequest = 1'b0;
        step();
        wait_for(SigWrd, 5, "wready_seen", n);
        check("wready_latency", 64'(n), 64'd0);
        bus.wvalid = 1'b0;
    endtask

    initial begin
        int base_acc;
        int base_pulses;
        int base_wstrobe;
        int base_wpulses;
        logic [31:0] burst_data [4];

        burst_data[0] = 32'h11110000;
        burst_data[1] = 32'h22220001;
        burst_data[2] = 32'h33330002;
        burst_data[3] = 32'h44440003;

        rst                   = 1'b1;
        bus.rvalid            = 1'b0;
        bus.raddr             = '0;
        bus.wvalid            = 1'b0;
        bus.waddr             = '0;
        bus.wdata             = '0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdata      = '0;
        bus.avm_readdatavalid = 1'b0;
        repeat (3) step();

        // Reset values.
        check("rst_rready", 64'(bus.rready), 64'd0);
        check("rst_wready", 64'(bus.wready), 64'd0);
        check("rst_avm_read", 64'(bus.avm_read), 64'd0);
        check("rst_avm_write", 64'(bus.avm_write), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        check("rst_avm_address", 64'(bus.avm_address), 64'd0);
        check("rst_avm_writedata", 64'(bus.avm_writedata), 64'd0);
        check("rst_rd_count", 64'(rd_count), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        check("byteenable", 64'(bus.avm_byteenable), 64'hF);
        rst = 1'b0;
        step();

        // Single read, data three cycles after acceptance.
        run_read(26'h0000010, 0, 3, 32'h0000ABCD, 1'b1);
        check("single_rd_addr_reg", 64'(bus.avm_address), 64'h0000040);
        repeat (2) step();
        check("single_rd_pulses", 64'(rd_pulses), 64'd1);
        check("single_rd_count", 64'(rd_count), 64'd1);
        check("single_rdata_hold", 64'(bus.rdata), 64'h0000ABCD);

        // Write with five wait-state cycles.
        base_wstrobe = wr_strobe_c;
        run_write(26'h0000100, 32'h00001234, 5);
        repeat (2) step();
        check("wr_strobe_cycles", 64'(wr_strobe_c - base_wstrobe), 64'd6);
        check("wr_pulses", 64'(wr_pulses), 64'd1);
        check("wr_count_1", 64'(wr_count), 64'd1);

        // Simultaneous requests: write must finish before the read is issued.
        base_acc   = acc_rd;
        bus.rvalid = 1'b1;
        bus.raddr  = 26'h0000055;
        run_write(26'h0000077, 32'hCAFEF00D, 1);
        check("both_no_read_yet", 64'(acc_rd - base_acc), 64'd0);
        run_read(26'h0000055, 0, 1, 32'h5555AAAA, 1'b1);
        repeat (2) step();
        check("both_acc_reads", 64'(acc_rd - base_acc), 64'd1);
        check("both_wr_count", 64'(wr_count), 64'd2);
        check("both_rd_count", 64'(rd_count), 64'd2);

        // Loader-style burst: next request the cycle after each rready.
        base_acc    = acc_rd;
        base_pulses = rd_pulses;
        for (int i = 0; i < 4; i++)
            run_read(26'h0000020 + 26'(i), i % 3, 1, burst_data[i], 1'b1);
        repeat (3) step();
        check("burst_acc_reads", 64'(acc_rd - base_acc), 64'd4);
        check("burst_pulses", 64'(rd_pulses - base_pulses), 64'd4);
        check("burst_rd_count", 64'(rd_count), 64'd6);
        check("burst_sb_empty", 64'(exp_raddr_q.size() + exp_rdata_q.size()), 64'd0);

        // Timeout at the top of the address range.
        run_read(26'h3FFFFFF, 0, 0, 32'h0, 1'b0);
        check("to_rdata", 64'(bus.rdata), 64'(TB_ERR));
        step();
        check("to_err_set", 64'(timeout_err), 64'd1);
        check("to_rd_count", 64'(rd_count), 64'd7);
        run_read(26'h0000001, 1, 2, 32'h01234567, 1'b1);
        repeat (2) step();
        check("to_err_sticky", 64'(timeout_err), 64'd1);
        check("to_rdata_next", 64'(bus.rdata), 64'h01234567);

        // Reset in S_RD_WAIT, stale readdatavalid afterwards.
        base_pulses  = rd_pulses;
        base_wpulses = wr_pulses;
        exp_raddr_q.push_back({26'h0000099, 2'b00});
        bus.rvalid = 1'b1;
        bus.raddr  = 26'h0000099;
        begin
            int n;
            wait_for(SigRd, 10, "rst_rd_strobe", n);
        end
        step();
        bus.rvalid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_avm_read", 64'(bus.avm_read), 64'd0);
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'h99999999;
        step();
        bus.avm_readdatavalid = 1'b0;
        repeat (4) step();
        check("abort_no_rready", 64'(rd_pulses - base_pulses), 64'd0);
        check("abort_no_wready", 64'(wr_pulses - base_wpulses), 64'd0);
        check("abort_rd_count", 64'(rd_count), 64'd0);
        check("abort_wr_count", 64'(wr_count), 64'd0);
        check("abort_timeout_err", 64'(timeout_err), 64'd0);
        check("abort_rdata", 64'(bus.rdata), 64'd0);
        check("abort_avm_address", 64'(bus.avm_address), 64'd0);
        check("abort_sb_empty", 64'(exp_raddr_q.size() + exp_rdata_q.size() + exp_wr_q.size()),
              64'd0);

        check("never_both_strobes", 64'(both_high), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
